pc_sequencer: RTL

- Instruction-fetch sequencer that sits directly downstream of the ALU. It consumes the ALU's doBranch result and owns the program counter that addresses instruction memory.
- Supports three kinds of next-PC: sequential increment, PC-relative branch (BEQ/B) and table-lookup branch (B_LOOKUP).
- Runs a start/done handshake with the testbench/top level and counts executed cycles.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/branch_lut.sv | 11 +
 rtl/pc_sequencer.sv | 82 ++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the instruction-fetch sequencer:
// state encoding, field widths and the branch target table.
package pc_pkg;

    localparam int unsigned PC_W      = 10;
    localparam int unsigned OFF_W     = 6;
    localparam int unsigned LUT_IDX_W = 4;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned LUT_DEPTH = 1 << LUT_IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Entries not listed by the assembler resolve to address 0
    localparam logic [PC_W-1:0] LUT_TARGETS [LUT_DEPTH] = '{
        10'd0,   10'd32,  10'd64,  10'd100,
        10'd200, 10'd512, 10'd0,   10'd0,
        10'd0,   10'd0,   10'd0,   10'd0,
        10'd0,   10'd0,   10'd0,   10'd0
    };

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the top level and the fetch sequencer.
interface pc_sequencer_if;
    import pc_pkg::*;

    logic                 start;
    logic [PC_W-1:0]      start_addr;
    logic                 stall;
    logic                 do_branch;
    logic                 br_lookup;
    logic [OFF_W-1:0]     br_offset;
    logic [LUT_IDX_W-1:0] lut_idx;
    logic                 halt_req;
    logic [PC_W-1:0]      prog_ctr;
    logic                 fetch_valid;
    logic                 done;
    logic [CNT_W-1:0]     cycle_cnt;

    modport master (
        output start, start_addr, stall, do_branch, br_lookup, br_offset, lut_idx, halt_req,
        input  prog_ctr, fetch_valid, done, cycle_cnt
    );

    modport slave (
        input  start, start_addr, stall, do_branch, br_lookup, br_offset, lut_idx, halt_req,
        output prog_ctr, fetch_valid, done, cycle_cnt
    );

endinterface

// File: rtl/branch_lut.sv
// Combinational ROM resolving a lookup-branch index to its target address.
module branch_lut
    import pc_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] i_idx,
    output logic [PC_W-1:0]      o_target
);

    assign o_target = LUT_TARGETS[i_idx];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: IDLE/RUN/HALT control, next-PC selection
// (sequential, relative, lookup) and a saturating executed-cycle counter.
module pc_sequencer
    import pc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    pc_sequencer_if.slave   bus
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     w_pc_nxt;
    logic                r_fetch_valid;
    logic                r_done;
    logic                w_done_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [PC_W-1:0]     w_lut_target;
    logic [PC_W-1:0]     w_off_ext;
    logic                w_step;

    branch_lut u_branch_lut (
        .i_idx    (bus.lut_idx),
        .o_target (w_lut_target)
    );

    assign w_off_ext = {{(PC_W-OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset};
    assign w_step    = (r_state == RUN) && !bus.stall;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_fetch_valid <= 1'b0;
            r_done        <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fetch_valid <= (w_state_nxt == RUN);
            r_done        <= w_done_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, HALT: if (bus.start) w_state_nxt = RUN;
            RUN:        if (w_step && bus.halt_req) w_state_nxt = HALT;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // Next output values; halt outranks branch, branch outranks increment
    always_comb begin
        w_pc_nxt   = r_pc;
        w_done_nxt = r_done;
        w_cnt_nxt  = r_cnt;
        if ((r_state != RUN) && bus.start) begin
            w_pc_nxt   = bus.start_addr;
            w_done_nxt = 1'b0;
            w_cnt_nxt  = '0;
        end else if (w_step) begin
            if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
            if (bus.halt_req)                      w_done_nxt = 1'b1;
            else if (bus.do_branch && bus.br_lookup) w_pc_nxt = w_lut_target;
            else if (bus.do_branch)                w_pc_nxt   = r_pc + w_off_ext;
            else                                   w_pc_nxt   = r_pc + PC_W'(1);
        end
    end

    assign bus.prog_ctr    = r_pc;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.done        = r_done;
    assign bus.cycle_cnt   = r_cnt;

endmodule
